// File: rtl/mastermind_pkg.sv
// Shared parameters, state encoding and feedback packing for the
// Mastermind scoring controller.
package mastermind_pkg;

    localparam int PEGS  = 4;
    localparam int CW    = 3;
    localparam int ROWS  = 6;
    localparam int RW    = 3;
    localparam int CNT_W = 3;
    localparam int FB_W  = 6;
    localparam int IW    = $clog2(PEGS);

    localparam logic [CW-1:0] COLOR_EMPTY = 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXACT,
        S_PARTIAL,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic [FB_W-1:0] pack_fb(
        input logic [CNT_W-1:0] ex,
        input logic [CNT_W-1:0] pa
    );
        return {ex, pa};
    endfunction

endpackage

// File: rtl/mastermind_peg_mux.sv
// Combinational selector returning one colour peg from a packed row bus.
import mastermind_pkg::*;

module mastermind_peg_mux (
    input  logic [PEGS*CW-1:0] bus,
    input  logic [IW-1:0]      sel,
    output logic [CW-1:0]      peg
);

    always_comb begin
        peg = COLOR_EMPTY;
        for (int k = 0; k < PEGS; k++) begin
            if (sel == IW'(k)) begin
                peg = bus[k*CW +: CW];
            end
        end
    end

endmodule

// File: rtl/mastermind_score_seq.sv
// Sequential exact/partial scorer: one peg comparison per cycle, then a
// handshaked write of the packed feedback into the row store.
import mastermind_pkg::*;

module mastermind_score_seq (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PEGS*CW-1:0] guess,
    input  logic [PEGS*CW-1:0] answer,
    input  logic [RW-1:0]      row,
    output logic               busy,
    output logic               done,
    output logic               bad_row,
    output logic [CNT_W-1:0]   exact,
    output logic [CNT_W-1:0]   partial,
    output logic               win,
    output logic               fb_we,
    output logic [RW-1:0]      fb_addr,
    output logic [FB_W-1:0]    fb_data,
    input  logic               fb_ready
);

    localparam logic [IW-1:0] LAST = IW'(PEGS - 1);

    state_t               state;
    logic [PEGS*CW-1:0]   g_reg;
    logic [PEGS*CW-1:0]   a_reg;
    logic [RW-1:0]        row_reg;
    logic [IW-1:0]        pi;
    logic [IW-1:0]        pj;
    logic [PEGS-1:0]      g_used;
    logic [PEGS-1:0]      a_used;

    logic [IW-1:0]        i_sel;
    logic [CW-1:0]        g_peg;
    logic [CW-1:0]        a_peg;
    logic                 same;
    logic                 exact_hit;
    logic                 partial_hit;
    logic [CNT_W-1:0]     partial_nxt;

    // The exact phase compares slot k against slot k, so both sides follow pj.
    assign i_sel = (state == S_PARTIAL) ? pi : pj;

    mastermind_peg_mux u_mux_i (
        .bus (g_reg),
        .sel (i_sel),
        .peg (g_peg)
    );

    mastermind_peg_mux u_mux_j (
        .bus (a_reg),
        .sel (pj),
        .peg (a_peg)
    );

    assign same        = (g_peg == a_peg) && (g_peg != COLOR_EMPTY);
    assign exact_hit   = same;
    assign partial_hit = same && !g_used[pi] && !a_used[pj];
    assign partial_nxt = partial + CNT_W'(partial_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            g_reg   <= '0;
            a_reg   <= '0;
            row_reg <= '0;
            pi      <= '0;
            pj      <= '0;
            g_used  <= '0;
            a_used  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bad_row <= 1'b0;
            exact   <= '0;
            partial <= '0;
            win     <= 1'b0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            done    <= 1'b0;
            bad_row <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (row < RW'(ROWS)) begin
                            g_reg   <= guess;
                            a_reg   <= answer;
                            row_reg <= row;
                            exact   <= '0;
                            partial <= '0;
                            win     <= 1'b0;
                            busy    <= 1'b1;
                            state   <= S_LOAD;
                        end else begin
                            bad_row <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    g_used  <= '0;
                    a_used  <= '0;
                    pi      <= '0;
                    pj      <= '0;
                    exact   <= '0;
                    partial <= '0;
                    state   <= S_EXACT;
                end
                S_EXACT: begin
                    if (exact_hit) begin
                        exact      <= exact + 1'b1;
                        g_used[pj] <= 1'b1;
                        a_used[pj] <= 1'b1;
                    end
                    if (pj == LAST) begin
                        pj    <= '0;
                        pi    <= '0;
                        state <= S_PARTIAL;
                    end else begin
                        pj <= pj + 1'b1;
                    end
                end
                S_PARTIAL: begin
                    partial <= partial_nxt;
                    if (partial_hit) begin
                        g_used[pi] <= 1'b1;
                        a_used[pj] <= 1'b1;
                    end
                    if (pj == LAST) begin
                        pj <= '0;
                        if (pi == LAST) begin
                            pi      <= '0;
                            fb_we   <= 1'b1;
                            fb_addr <= row_reg;
                            fb_data <= pack_fb(exact, partial_nxt);
                            state   <= S_WRITE;
                        end else begin
                            pi <= pi + 1'b1;
                        end
                    end else begin
                        pj <= pj + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (fb_ready) begin
                        fb_we <= 1'b0;
                        done  <= 1'b1;
                        win   <= (exact == CNT_W'(PEGS));
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mastermind_score_seq.sv
// Directed bench for mastermind_score_seq with a colour-count scoring model
// and a cycle timeline model checked on every falling edge.
module tb_mastermind_score_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] guess = '0;
    logic [11:0] answer = '0;
    logic [2:0]  row = '0;
    logic        busy;
    logic        done;
    logic        bad_row;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic        win;
    logic        fb_we;
    logic [2:0]  fb_addr;
    logic [5:0]  fb_data;
    logic        fb_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int writes = 0;
    bit chk_en = 1'b0;

    mastermind_score_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .guess    (guess),
        .answer   (answer),
        .row      (row),
        .busy     (busy),
        .done     (done),
        .bad_row  (bad_row),
        .exact    (exact),
        .partial  (partial),
        .win      (win),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Mastermind score by colour counts: exact slots, then per-colour minimum
    // of the leftover pegs on each side.
    function automatic void score(input logic [11:0] g, input logic [11:0] a,
                                  output int e, output int p);
        int gc[8];
        int ac[8];
        logic [2:0] gk;
        logic [2:0] ak;
        e = 0;
        p = 0;
        for (int c = 0; c < 8; c++) begin
            gc[c] = 0;
            ac[c] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            gk = g[k*3 +: 3];
            ak = a[k*3 +: 3];
            if (gk == ak && gk != 3'd0) begin
                e++;
            end else begin
                if (gk != 3'd0) gc[gk]++;
                if (ak != 3'd0) ac[ak]++;
            end
        end
        for (int c = 1; c < 8; c++) begin
            p += (gc[c] < ac[c]) ? gc[c] : ac[c];
        end
    endfunction

    // Timeline model: m_age is the cycle number since the accepting edge
    // (0 = idle, 1..21 scoring, 22 writing, 23 done).
    int         m_age = 0;
    bit         m_bad = 1'b0;
    int         m_fe = 0;
    int         m_fp = 0;
    int         m_e = 0;
    int         m_p = 0;
    bit         m_win = 1'b0;
    logic [2:0] m_row = '0;
    int         fe;
    int         fp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age <= 0;
            m_bad <= 1'b0;
            m_e   <= 0;
            m_p   <= 0;
            m_win <= 1'b0;
            m_row <= '0;
        end else begin
            m_bad <= (m_age == 0) && start && (row >= 3'd6);
            if (m_age == 0) begin
                if (start && row < 3'd6) begin
                    score(guess, answer, fe, fp);
                    m_fe  <= fe;
                    m_fp  <= fp;
                    m_age <= 1;
                    m_e   <= 0;
                    m_p   <= 0;
                    m_win <= 1'b0;
                    m_row <= row;
                end
            end else if (m_age < 21) begin
                m_age <= m_age + 1;
            end else if (m_age == 21) begin
                m_age <= 22;
                m_e   <= m_fe;
                m_p   <= m_fp;
            end else if (m_age == 22) begin
                if (fb_ready) begin
                    m_age <= 23;
                    m_win <= (m_fe == 4);
                end
            end else begin
                m_age <= 0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && fb_we && fb_ready) writes <= writes + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(m_age != 0));
            chk("fb_we", int'(fb_we), int'(m_age == 22));
            chk("done", int'(done), int'(m_age == 23));
            chk("bad_row", int'(bad_row), int'(m_bad));
            chk("win", int'(win), int'(m_win));
            if (m_age == 0 || m_age == 1 || m_age >= 22) begin
                chk("exact", int'(exact), m_e);
                chk("partial", int'(partial), m_p);
            end
            if (m_age == 22) begin
                chk("fb_addr", int'(fb_addr), int'(m_row));
                chk("fb_data", int'(fb_data), m_e * 8 + m_p);
            end
        end
    end

    task automatic run(input logic [11:0] g, input logic [11:0] a,
                       input logic [2:0] r, input int stall, input bit inject,
                       input int ee, input int pp, input int ww,
                       input int fbd, input int done_at);
        int  n;
        int  left;
        bit  seen;
        @(negedge clk);
        guess    = g;
        answer   = a;
        row      = r;
        start    = 1'b1;
        fb_ready = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        guess  = 12'($urandom);
        answer = 12'($urandom);
        row    = 3'($urandom);
        left   = stall;
        seen   = 1'b0;
        n      = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            start = inject && (n == 10);
            if (fb_we) begin
                chk("lit_fb_data", int'(fb_data), fbd);
                chk("lit_fb_addr", int'(fb_addr), int'(r));
            end
            if (fb_we && left > 0) begin
                fb_ready = 1'b0;
                left--;
            end else begin
                fb_ready = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                chk("lit_done_cycle", n, done_at);
                chk("lit_exact", int'(exact), ee);
                chk("lit_partial", int'(partial), pp);
                chk("lit_win", int'(win), ww);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        start    = 1'b0;
        fb_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int w0;
        #1;
        rst_n = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_exact", int'(exact), 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(12'b001_001_001_001, 12'b001_001_001_001, 3'd0, 0, 1'b0,
            4, 0, 1, 6'b100_000, 23);
        run(12'b100_011_010_001, 12'b001_010_011_100, 3'd5, 0, 1'b0,
            0, 4, 0, 6'b000_100, 23);
        run(12'b001_010_001_011, 12'b001_001_010_010, 3'd2, 0, 1'b0,
            1, 2, 0, 6'b001_010, 23);
        run(12'h000, 12'h000, 3'd1, 0, 1'b0,
            0, 0, 0, 6'b000_000, 23);
        run(12'b001_010_001_011, 12'b001_001_010_010, 3'd3, 5, 1'b1,
            1, 2, 0, 6'b001_010, 28);

        w0 = writes;
        @(negedge clk);
        guess  = 12'b001_001_001_001;
        answer = 12'b001_001_001_001;
        row    = 3'd4;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_fb_we", int'(fb_we), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_write", writes, w0);

        @(negedge clk);
        row   = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("lit_bad_row_hi", int'(bad_row), 1);
        chk("lit_bad_busy", int'(busy), 0);
        @(negedge clk);
        chk("lit_bad_row_lo", int'(bad_row), 0);
        repeat (25) @(negedge clk);
        chk("bad_no_write", writes, w0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
